// File: rtl/mem_stage_mmio.sv
// Memory pipeline stage: multi-cycle data memory with stall handshake,
// sub-word loads/stores with misalignment detection, and memory-mapped SW/LED channels.
module mem_stage_mmio #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned NUM_IO      = 4,
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FFF0
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Mem_R_En,
    input  logic                  Mem_W_En,
    input  logic [2:0]            Funct3,
    input  logic                  Reg_W_En_IN,
    input  logic [1:0]            WBsel_IN,
    input  logic [31:0]           ALURes_IN,
    input  logic [31:0]           PCplus4_IN,
    input  logic [31:0]           rd2,
    input  logic [31:0]           Instruction_IN,
    input  logic [32*NUM_IO-1:0]  SW,
    output logic [32*NUM_IO-1:0]  LED,
    output logic                  Stall,
    output logic                  Misaligned,
    output logic                  Reg_W_En,
    output logic [1:0]            WBsel,
    output logic [31:0]           ALURes,
    output logic [31:0]           PCplus4,
    output logic [31:0]           Instruction,
    output logic [31:0]           Mem_Data_or_SW
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [31:0]             rdata_q;
    logic [31:0]             mem [DEPTH];

    logic [NUM_IO-1:0]       io_match;
    logic                    io_hit;
    logic [31:0]             io_rdata;
    logic                    is_byte, is_half, is_word;
    logic                    misalign_raw, mem_req, is_load, commit;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [3:0]              byte_en;
    logic [31:0]             wdata;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;

    assign Reg_W_En    = Reg_W_En_IN;
    assign WBsel       = WBsel_IN;
    assign ALURes      = ALURes_IN;
    assign PCplus4     = PCplus4_IN;
    assign Instruction = Instruction_IN;

    // Address decode: IO channel match or aliased memory word index
    always_comb begin
        io_match = '0;
        io_rdata = '0;
        for (int unsigned k = 0; k < NUM_IO; k++) begin
            if (ALURes_IN == IO_BASE + 32'(4 * k)) begin
                io_match[k] = 1'b1;
                io_rdata    = SW[32*k +: 32];
            end
        end
    end

    assign io_hit   = |io_match;
    assign word_idx = ALURes_IN[ADDR_WIDTH+1:2];
    assign is_byte  = (Funct3 == 3'b000) || (Funct3 == 3'b100);
    assign is_half  = (Funct3 == 3'b001) || (Funct3 == 3'b101);
    assign is_word  = !is_byte && !is_half;
    assign is_load  = Mem_R_En && !Mem_W_En;

    assign misalign_raw = !io_hit && (Mem_R_En || Mem_W_En) &&
                          ((is_half && ALURes_IN[0]) || (is_word && ALURes_IN[1:0] != 2'b00));
    assign mem_req      = !io_hit && (Mem_R_En || Mem_W_En) && !misalign_raw;
    assign commit       = !Reset && (state == WAIT) && (cnt == '0);

    assign Misaligned = misalign_raw && !Reset;
    assign Stall      = !Reset && (((state == IDLE) && mem_req) || (state == WAIT));

    // Store lane enables and replicated store data
    always_comb begin
        byte_en = 4'b1111;
        wdata   = rd2;
        if (is_byte) begin
            byte_en = 4'b0001 << ALURes_IN[1:0];
            wdata   = {4{rd2[7:0]}};
        end else if (is_half) begin
            byte_en = ALURes_IN[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{rd2[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (commit && Mem_W_En) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Access FSM, read capture and LED registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            LED     <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_IO; k++) begin
                if (Mem_W_En && io_match[k]) LED[32*k +: 32] <= rd2;
            end
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        state <= WAIT;
                        cnt   <= CNT_W'(MEM_LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= DONE;
                        if (is_load) rdata_q <= mem[word_idx];
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign byte_sel = rdata_q[{ALURes_IN[1:0], 3'b000} +: 8];
    assign half_sel = ALURes_IN[1] ? rdata_q[31:16] : rdata_q[15:0];

    // Load result: IO switches, extended memory data in DONE, else zero
    always_comb begin
        Mem_Data_or_SW = '0;
        if (is_load && io_hit) begin
            Mem_Data_or_SW = io_rdata;
        end else if (is_load && state == DONE) begin
            if (is_byte)
                Mem_Data_or_SW = Funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            else if (is_half)
                Mem_Data_or_SW = Funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            else
                Mem_Data_or_SW = rdata_q;
        end
    end
endmodule

// File: tb/tb_mem_stage_mmio.sv
// Self-checking bench for mem_stage_mmio: byte-array memory model, per-cycle
// stall/result checks, directed scenarios with literal expectations, then random traffic.
module tb_mem_stage_mmio;
    localparam int unsigned AW  = 10;
    localparam int unsigned NIO = 4;
    localparam int unsigned LAT = 2;
    localparam logic [31:0] IOB = 32'hFFFF_FFF0;

    logic               clk = 1'b0;
    logic               Reset;
    logic               Mem_R_En, Mem_W_En;
    logic [2:0]         Funct3;
    logic               Reg_W_En_IN;
    logic [1:0]         WBsel_IN;
    logic [31:0]        ALURes_IN, PCplus4_IN, rd2, Instruction_IN;
    logic [32*NIO-1:0]  SW, LED;
    logic               Stall, Misaligned, Reg_W_En;
    logic [1:0]         WBsel;
    logic [31:0]        ALURes, PCplus4, Instruction, Mem_Data_or_SW;

    mem_stage_mmio #(.ADDR_WIDTH(AW), .NUM_IO(NIO), .MEM_LATENCY(LAT), .IO_BASE(IOB)) dut (
        .clk(clk), .Reset(Reset), .Mem_R_En(Mem_R_En), .Mem_W_En(Mem_W_En), .Funct3(Funct3),
        .Reg_W_En_IN(Reg_W_En_IN), .WBsel_IN(WBsel_IN), .ALURes_IN(ALURes_IN),
        .PCplus4_IN(PCplus4_IN), .rd2(rd2), .Instruction_IN(Instruction_IN), .SW(SW), .LED(LED),
        .Stall(Stall), .Misaligned(Misaligned), .Reg_W_En(Reg_W_En), .WBsel(WBsel),
        .ALURes(ALURes), .PCplus4(PCplus4), .Instruction(Instruction),
        .Mem_Data_or_SW(Mem_Data_or_SW)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  mb [4*(1<<AW)];
    logic [31:0] led_m [NIO];
    logic [31:0] sw_v  [NIO];
    logic [31:0] last_data;
    int          last_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sz(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    // Byte offset in the model of the first byte touched by an access
    function automatic int unsigned m_addr(input logic [31:0] a, input logic [2:0] f3);
        int unsigned base = ((a >> 2) & ((1 << AW) - 1)) * 4;
        if (sz(f3) == 1) return base + (a & 3);
        if (sz(f3) == 2) return base + (a & 2);
        return base;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3);
        int          s  = sz(f3);
        int unsigned ba = m_addr(a, f3);
        logic [31:0] v  = 32'h0;
        for (int i = 0; i < s; i++) v = v | (32'(mb[ba + i]) << (8 * i));
        if (s < 4 && f3 < 3'd4 && v >= 32'(1 << (8 * s - 1))) v = v - 32'(1 << (8 * s));
        return v;
    endfunction

    function automatic void m_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        int unsigned ba = m_addr(a, f3);
        for (int i = 0; i < sz(f3); i++) mb[ba + i] = 8'(d >> (8 * i));
    endfunction

    task automatic chk_leds();
        for (int k = 0; k < NIO; k++) chk("led", LED[32*k +: 32], led_m[k]);
    endtask

    // One transaction, starting and ending on a falling edge; checks every cycle
    task automatic txn(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
        int          kio = -1;
        bit          mis, memop;
        int          ncyc;
        logic [31:0] exp_data = 32'h0;
        logic [31:0] instr = $urandom;
        logic [31:0] pc = $urandom;
        logic [2:0]  ctl = 3'($urandom);
        for (int k = 0; k < NIO; k++) if (a == IOB + 32'(4 * k)) kio = k;
        mis   = (kio < 0) && (r || w) &&
                ((sz(f3) == 2 && a[0]) || (sz(f3) == 4 && a[1:0] != 2'b00));
        memop = (kio < 0) && (r || w) && !mis;
        ncyc  = memop ? LAT + 2 : 1;
        if (r && !w) begin
            if (kio >= 0) exp_data = sw_v[kio];
            else if (memop) exp_data = m_load(a, f3);
        end
        for (int k = 0; k < NIO; k++) SW[32*k +: 32] = sw_v[k];
        Mem_R_En = r; Mem_W_En = w; Funct3 = f3; ALURes_IN = a; rd2 = d;
        Instruction_IN = instr; PCplus4_IN = pc; {Reg_W_En_IN, WBsel_IN} = ctl;
        last_stalls = 0;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (Stall) last_stalls++;
            chk("stall", 32'(Stall), 32'(memop && c <= LAT));
            chk("misaligned", 32'(Misaligned), 32'(mis));
            chk("rdata", Mem_Data_or_SW, (c == ncyc - 1) ? exp_data : 32'h0);
            if (c == 0) begin
                chk("pass_alu", ALURes, a);
                chk("pass_instr", Instruction, instr);
                chk("pass_pc", PCplus4, pc);
                chk("pass_ctl", 32'({Reg_W_En, WBsel}), 32'(ctl));
            end
            chk_leds();
            if (c == ncyc - 1) last_data = Mem_Data_or_SW;
            @(negedge clk);
        end
        if (w && kio >= 0) led_m[kio] = d;
        else if (w && memop) m_store(a, f3, d);
        Mem_R_En = 1'b0; Mem_W_En = 1'b0;
        chk_leds();
    endtask

    initial begin
        for (int k = 0; k < NIO; k++) begin
            led_m[k] = 32'h0;
            sw_v[k]  = $urandom;
        end
        Reset = 1'b1; Mem_R_En = 1'b0; Mem_W_En = 1'b0; Funct3 = 3'd2; ALURes_IN = 32'h0;
        rd2 = 32'h0; Instruction_IN = 32'h0; PCplus4_IN = 32'h0; Reg_W_En_IN = 1'b0; WBsel_IN = 2'd0;
        SW = '0;
        @(negedge clk);
        // Reset state; flags forced low even with a misaligned request present
        Mem_R_En = 1'b1; ALURes_IN = 32'h11;
        #1;
        chk("reset_stall", 32'(Stall), 32'h0);
        chk("reset_misaligned", 32'(Misaligned), 32'h0);
        chk("reset_rdata", Mem_Data_or_SW, 32'h0);
        @(negedge clk);
        #1;
        chk_leds();
        Reset = 1'b0; Mem_R_En = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) txn(1'b0, 1'b1, 3'd2, 32'(i * 4), 32'h0);

        // Full word store and load
        txn(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        chk("sw_stall_cycles", 32'(last_stalls), 32'd3);
        txn(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        chk("lw_stall_cycles", 32'(last_stalls), 32'd3);
        chk("lw_literal", last_data, 32'hDEAD_BEEF);

        // Byte store, signed and unsigned byte loads
        txn(1'b0, 1'b1, 3'd0, 32'h13, 32'h0000_0080);
        txn(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        chk("sb_word_literal", last_data, 32'h80AD_BEEF);
        txn(1'b1, 1'b0, 3'd0, 32'h13, 32'h0);
        chk("lb_literal", last_data, 32'hFFFF_FF80);
        txn(1'b1, 1'b0, 3'd4, 32'h13, 32'h0);
        chk("lbu_literal", last_data, 32'h0000_0080);

        // Halfword store/load and misaligned accesses
        txn(1'b0, 1'b1, 3'd1, 32'h12, 32'h0000_1234);
        txn(1'b1, 1'b0, 3'd1, 32'h12, 32'h0);
        chk("lh_literal", last_data, 32'h0000_1234);
        txn(1'b1, 1'b0, 3'd2, 32'h11, 32'h0);
        chk("mis_rdata_literal", last_data, 32'h0);
        chk("mis_stall_literal", 32'(last_stalls), 32'd0);
        txn(1'b0, 1'b1, 3'd1, 32'h11, 32'hFFFF_FFFF);
        txn(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        chk("sh_word_literal", last_data, 32'h1234_BEEF);

        // Memory-mapped IO
        txn(1'b0, 1'b1, 3'd0, 32'hFFFF_FFF8, 32'hA5A5_A5A5);
        chk("led2_literal", LED[95:64], 32'hA5A5_A5A5);
        chk("led0_literal", LED[31:0], 32'h0);
        chk("io_stall_literal", 32'(last_stalls), 32'd0);
        sw_v[3] = 32'h55;
        txn(1'b1, 1'b0, 3'd0, 32'hFFFF_FFFC, 32'h0);
        chk("sw3_literal", last_data, 32'h55);
        txn(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF0, 32'h1357_9BDF);

        // Reset landing on the commit edge of a store drops the store
        for (int k = 0; k < NIO; k++) SW[32*k +: 32] = sw_v[k];
        Mem_R_En = 1'b0; Mem_W_En = 1'b1; Funct3 = 3'd2; ALURes_IN = 32'h20; rd2 = 32'h1234_5678;
        #1; chk("rst_seq_stall0", 32'(Stall), 32'h1);
        @(negedge clk);
        #1; chk("rst_seq_stall1", 32'(Stall), 32'h1);
        @(negedge clk);
        Reset = 1'b1;
        #1; chk("rst_seq_forced", 32'(Stall), 32'h0);
        @(negedge clk);
        Reset = 1'b0; Mem_W_En = 1'b0;
        for (int k = 0; k < NIO; k++) led_m[k] = 32'h0;
        #1;
        chk("rst_seq_idle", 32'(Stall), 32'h0);
        chk_leds();
        @(negedge clk);
        txn(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
        chk("rst_dropped_literal", last_data, 32'h0);

        // Read and write together behaves as a store
        txn(1'b1, 1'b1, 3'd2, 32'h30, 32'hCAFE_F00D);
        chk("rw_stall_literal", 32'(last_stalls), 32'd3);
        chk("rw_rdata_literal", last_data, 32'h0);
        txn(1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
        chk("rw_reload_literal", last_data, 32'hCAFE_F00D);

        // Random traffic across memory space (with aliasing), IO and all Funct3 codes
        for (int i = 0; i < 300; i++) begin
            int unsigned sel = $urandom_range(0, 9);
            int unsigned rw  = $urandom_range(0, 3);
            logic [31:0] a;
            for (int k = 0; k < NIO; k++) sw_v[k] = $urandom;
            if (sel < 3) a = IOB + 32'(4 * $urandom_range(0, NIO - 1));
            else a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            txn(rw[0], rw[1], 3'($urandom), a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_mmio.md
Name: mem_stage_mmio

Overview:
Parametrised successor memory stage for the five-stage pipeline, sitting between EX/MEM and MEM/WB.
- Adds a multi-cycle data memory with a Stall handshake.
- Supports byte and halfword loads/stores with sign or zero extension, plus misalignment detection.
- Provides NUM_IO memory-mapped switch-input and LED-output channels.
- Pipeline control and value fields pass through unchanged.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH 32-bit words
NUM_IO, 4, number of SW/LED channel pairs (1..4)
MEM_LATENCY, 2, cycles of data-memory access time L (>=1)
IO_BASE, 32'hFFFFFFF0, byte address of channel 0; channel k at IO_BASE+4k

Ports:
clk  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
Mem_R_En  in  1  load request
Mem_W_En  in  1  store request
Funct3  in  3  access size/sign, RISC-V encoding
Reg_W_En_IN  in  1  passthrough
WBsel_IN  in  2  passthrough
ALURes_IN  in  32  byte address / passthrough
PCplus4_IN  in  32  passthrough
rd2  in  32  store data
Instruction_IN  in  32  passthrough
SW  in  32*NUM_IO  switch inputs, channel k = bits [32k+31:32k]
LED  out  32*NUM_IO  LED registers, same slicing
Stall  out  1  high: upstream must hold all inputs stable
Misaligned  out  1  combinational misaligned-access flag
Reg_W_En, WBsel, ALURes, PCplus4, Instruction  out  1/2/32/32/32  combinational copies of the _IN inputs
Mem_Data_or_SW  out  32  load result

Behaviour:
- Decode (combinational):
  - IO hit k: ALURes_IN == IO_BASE+4k, k<NUM_IO.
  - Otherwise, memory space: word index ALURes_IN[ADDR_WIDTH+1:2]; upper bits ignored (aliasing).
- Funct3 sizes: 000 B, 001 H, 010 W, 100 BU, 101 HU. Codes 011/110/111 are treated as W.
- Misaligned (memory space only, R or W high): H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Effect: no access, no stall, store dropped, Mem_Data_or_SW=0.
- IO access (Funct3 ignored, always full word, never stalls, never misaligned):
  - Store: LED slice k <= rd2 at the next edge.
  - Load: Mem_Data_or_SW = SW slice k, combinational.
- Mem_R_En and Mem_W_En both high: treated as a store; Mem_Data_or_SW=0.
- FSM for aligned memory-space requests, states IDLE, WAIT, DONE; 2-bit state; counter cnt of clog2(L)+1 bits:
  - IDLE, no request: Stall=0.
  - IDLE, request: Stall=1, cnt<=L-1, go to WAIT.
  - WAIT: Stall=1. If cnt!=0, cnt<=cnt-1. If cnt==0, the access is performed at this edge, then go to DONE:
    - write commits byte lanes to memory;
    - read captures the full word into rdata_q.
  - DONE: Stall=0; loads drive the extended rdata_q. Go to IDLE unconditionally; DONE never re-triggers on the still-present request.
  - A memory request therefore holds Stall high for L+1 cycles and completes in the (L+2)th cycle.
- Store lanes:
  - SB writes lane addr[1:0] with rd2[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with rd2[15:0].
  - SW writes all four lanes.
  - Unwritten lanes keep their value.
- Load extract: select byte/half by addr, then sign-extend (B/H) or zero-extend (BU/HU).
- Mem_Data_or_SW is 0 whenever no IO load is present and the FSM is not in DONE with a load.
- Reset (synchronous):
  - state=IDLE, cnt=0, rdata_q=0, all LED=0.
  - Stall and Misaligned forced to 0 while Reset is high.
  - Memory array not reset.
  - Reset during WAIT aborts the access; a write whose commit edge coincides with Reset is dropped.
- Upstream must not change inputs while Stall=1. Behaviour with inputs changed under stall is undefined.

Test Plan:
1. L=2, SW to 0x10 with rd2=0xDEADBEEF, then LW 0x10 -> Stall high exactly 3 cycles per access; load DONE cycle gives Mem_Data_or_SW=0xDEADBEEF.
2. SB rd2=0x80 to 0x13, then LB 0x13 and LBU 0x13 -> memory word 0x80ADBEEF; LB returns 0xFFFFFF80, LBU returns 0x00000080.
3. SH rd2=0x1234 to 0x12, then LH 0x12 -> returns 0x00001234; word reads 0x1234BEEF. LW 0x11 -> Misaligned=1, Stall=0, result 0, memory unchanged.
4. Store 0xA5A5A5A5 to 0xFFFFFFF8 -> LED slice 2 = 0xA5A5A5A5 next cycle, other slices 0, no stall. SW slice 3=0x55 with LW 0xFFFFFFFC -> Mem_Data_or_SW=0x55 same cycle.
5. Assert Reset in the WAIT cycle of an SW to 0x20 (old value 0x0) -> state IDLE, Stall=0, LEDs 0; LW 0x20 afterwards returns 0x0.
6. Mem_R_En and Mem_W_En both high, SW to 0x30 -> treated as a store with the normal 3-cycle stall; Mem_Data_or_SW=0; later LW 0x30 returns rd2.
